ddr_cmd_sequencer: RTL and testbench

//  Downstream of the 16-entry trace request queue; pops one request at a time (valid/ready).

---
 rtl/ddr_pkg.sv | 64 ++++++
 rtl/ddr_bank_tracker.sv | 58 +++++
 rtl/ddr_cmd_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_ddr_cmd_sequencer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/ddr_pkg.sv
// Shared types for the DDR command sequencer: command/op encodings, FSM states,
// address field layout and the address decode helper.
package ddr_pkg;

    localparam int NUM_BG    = 4;
    localparam int NUM_BANK  = 4;
    localparam int NUM_BANKS = NUM_BG * NUM_BANK;
    localparam int ROW_W     = 15;
    localparam int COL_W     = 11;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_e;

    typedef enum logic [1:0] {
        OP_READ    = 2'd0,
        OP_WRITE   = 2'd1,
        OP_FETCH   = 2'd2,
        OP_ILLEGAL = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_PRE_WAIT_RAS = 3'd1,
        S_PRE_ISSUE    = 3'd2,
        S_RP_WAIT      = 3'd3,
        S_ACT_ISSUE    = 3'd4,
        S_RCD_WAIT     = 3'd5,
        S_COL_ISSUE    = 3'd6,
        S_BURST_WAIT   = 3'd7
    } seq_state_e;

    typedef struct packed {
        logic [ROW_W-1:0] row;
        logic [7:0]       high_col;
        logic [1:0]       bank;
        logic [1:0]       bg;
        logic [2:0]       low_col;
    } addr_fields_t;

    // Byte-within-burst bits [2:0] never reach the command bus, so they are dropped here.
    function automatic addr_fields_t decode_addr(input logic [32:0] addr);
        addr_fields_t f;
        f.low_col  = addr[5:3];
        f.bg       = addr[7:6];
        f.bank     = addr[9:8];
        f.high_col = addr[17:10];
        f.row      = addr[32:18];
        return f;
    endfunction

    function automatic logic [3:0] bank_idx(input addr_fields_t f);
        return {f.bg, f.bank};
    endfunction

    function automatic cmd_e col_cmd(input op_e op);
        return (op == OP_WRITE) ? CMD_WR : CMD_RD;
    endfunction

endpackage

// File: rtl/ddr_bank_tracker.sv
// Open-row table for all 16 banks plus a per-bank tRAS down-counter that
// gates precharge; lookup is combinational for the queried bank.
module ddr_bank_tracker
    import ddr_pkg::*;
#(
    parameter int T_RAS = 52
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             act_en,
    input  logic             pre_en,
    input  logic [3:0]       upd_idx,
    input  logic [ROW_W-1:0] act_row,
    input  logic [3:0]       q_idx,
    input  logic [ROW_W-1:0] q_row,
    output logic             q_hit,
    output logic             q_open,
    output logic             q_ras_ok
);

    localparam int RAS_W = $clog2(T_RAS) + 1;
    localparam logic [RAS_W-1:0] RAS_LOAD = RAS_W'(T_RAS - 1);

    logic [NUM_BANKS-1:0] open_r;
    logic [ROW_W-1:0]     row_r [NUM_BANKS];
    logic [RAS_W-1:0]     ras_r [NUM_BANKS];

    // Every bank's counter keeps running regardless of which bank the FSM is serving.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            open_r <= '0;
            for (int i = 0; i < NUM_BANKS; i++) begin
                row_r[i] <= '0;
                ras_r[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_BANKS; i++) begin
                if (act_en && upd_idx == 4'(i)) begin
                    open_r[i] <= 1'b1;
                    row_r[i]  <= act_row;
                    ras_r[i]  <= RAS_LOAD;
                end else begin
                    if (pre_en && upd_idx == 4'(i)) begin
                        open_r[i] <= 1'b0;
                    end
                    if (ras_r[i] != '0) begin
                        ras_r[i] <= ras_r[i] - RAS_W'(1);
                    end
                end
            end
        end
    end

    assign q_open   = open_r[q_idx];
    assign q_hit    = open_r[q_idx] && (row_r[q_idx] == q_row);
    assign q_ras_ok = (ras_r[q_idx] == '0);

endmodule

// File: rtl/ddr_cmd_sequencer.sv
// Pops one request at a time and emits PRE/ACT/RD/WR pulses under an open-page
// policy, honouring tRCD, tRP, tRAS and burst spacing.
module ddr_cmd_sequencer
    import ddr_pkg::*;
#(
    parameter int T_RCD   = 24,
    parameter int T_RP    = 24,
    parameter int T_RAS   = 52,
    parameter int T_BURST = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [32:0]      req_addr,
    output logic             cmd_valid,
    output logic [2:0]       cmd_type,
    output logic [1:0]       cmd_bg,
    output logic [1:0]       cmd_bank,
    output logic [ROW_W-1:0] cmd_row,
    output logic [COL_W-1:0] cmd_col,
    output logic             req_done,
    output logic             req_err,
    output seq_state_e       state_dbg
);

    // Handshake: a request transfers on a rising edge where req_valid && req_ready;
    // req_ready is high only in IDLE, and the queue holds its head while it is low.

    localparam int MAX_AB = (T_RCD > T_RP) ? T_RCD : T_RP;
    localparam int MAX_CD = (T_RAS > T_BURST) ? T_RAS : T_BURST;
    localparam int MAX_T  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int CNT_W  = $clog2(MAX_T) + 1;

    // A wait state covers T-1 cycles, counting down to 0 before the next command.
    localparam logic [CNT_W-1:0] RCD_LOAD   = CNT_W'((T_RCD   >= 2) ? T_RCD   - 2 : 0);
    localparam logic [CNT_W-1:0] RP_LOAD    = CNT_W'((T_RP    >= 2) ? T_RP    - 2 : 0);
    localparam logic [CNT_W-1:0] BURST_LOAD = CNT_W'((T_BURST >= 2) ? T_BURST - 2 : 0);

    seq_state_e   state;
    logic [CNT_W-1:0] wait_cnt;
    op_e          op_q;
    addr_fields_t fld_q;
    addr_fields_t q_fld;
    cmd_e         next_cmd;
    logic         q_hit;
    logic         q_open;
    logic         q_ras_ok;
    logic         next_is_col;

    assign q_fld       = (state == S_IDLE) ? decode_addr(req_addr) : fld_q;
    assign next_is_col = (next_cmd == CMD_RD) || (next_cmd == CMD_WR);
    assign state_dbg   = state;

    ddr_bank_tracker #(.T_RAS(T_RAS)) u_tracker (
        .clk      (clk),
        .rst      (rst),
        .act_en   (next_cmd == CMD_ACT),
        .pre_en   (next_cmd == CMD_PRE),
        .upd_idx  (bank_idx(q_fld)),
        .act_row  (q_fld.row),
        .q_idx    (bank_idx(q_fld)),
        .q_row    (q_fld.row),
        .q_hit    (q_hit),
        .q_open   (q_open),
        .q_ras_ok (q_ras_ok)
    );

    // The command launched on the next edge; it also strobes the bank tracker.
    always_comb begin
        next_cmd = CMD_NOP;
        case (state)
            S_IDLE: begin
                if (req_valid && op_e'(req_op) != OP_ILLEGAL) begin
                    if (q_hit)         next_cmd = col_cmd(op_e'(req_op));
                    else if (!q_open)  next_cmd = CMD_ACT;
                    else if (q_ras_ok) next_cmd = CMD_PRE;
                end
            end
            S_PRE_WAIT_RAS: if (q_ras_ok)       next_cmd = CMD_PRE;
            S_PRE_ISSUE:    if (T_RP == 1)      next_cmd = CMD_ACT;
            S_RP_WAIT:      if (wait_cnt == '0) next_cmd = CMD_ACT;
            S_ACT_ISSUE:    if (T_RCD == 1)     next_cmd = col_cmd(op_q);
            S_RCD_WAIT:     if (wait_cnt == '0) next_cmd = col_cmd(op_q);
            default:        next_cmd = CMD_NOP;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            op_q      <= OP_READ;
            fld_q     <= '0;
            req_ready <= 1'b1;
            cmd_valid <= 1'b0;
            cmd_type  <= 3'd0;
            cmd_bg    <= 2'd0;
            cmd_bank  <= 2'd0;
            cmd_row   <= '0;
            cmd_col   <= '0;
            req_done  <= 1'b0;
            req_err   <= 1'b0;
        end else begin
            cmd_valid <= (next_cmd != CMD_NOP);
            cmd_type  <= next_cmd;
            cmd_bg    <= (next_cmd != CMD_NOP) ? q_fld.bg   : 2'd0;
            cmd_bank  <= (next_cmd != CMD_NOP) ? q_fld.bank : 2'd0;
            cmd_row   <= (next_cmd == CMD_ACT) ? q_fld.row  : '0;
            cmd_col   <= next_is_col ? {q_fld.high_col, q_fld.low_col} : '0;
            req_done  <= next_is_col;
            req_err   <= 1'b0;

            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        op_q  <= op_e'(req_op);
                        fld_q <= q_fld;
                        if (op_e'(req_op) == OP_ILLEGAL) begin
                            req_err <= 1'b1;
                        end else begin
                            req_ready <= 1'b0;
                            case (next_cmd)
                                CMD_ACT:        state <= S_ACT_ISSUE;
                                CMD_PRE:        state <= S_PRE_ISSUE;
                                CMD_RD, CMD_WR: state <= S_COL_ISSUE;
                                default:        state <= S_PRE_WAIT_RAS;
                            endcase
                        end
                    end
                end
                S_PRE_WAIT_RAS: begin
                    if (next_cmd == CMD_PRE) state <= S_PRE_ISSUE;
                end
                S_PRE_ISSUE: begin
                    if (T_RP == 1) begin
                        state <= S_ACT_ISSUE;
                    end else begin
                        state    <= S_RP_WAIT;
                        wait_cnt <= RP_LOAD;
                    end
                end
                S_RP_WAIT: begin
                    if (wait_cnt == '0) state <= S_ACT_ISSUE;
                    else                wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_ACT_ISSUE: begin
                    if (T_RCD == 1) begin
                        state <= S_COL_ISSUE;
                    end else begin
                        state    <= S_RCD_WAIT;
                        wait_cnt <= RCD_LOAD;
                    end
                end
                S_RCD_WAIT: begin
                    if (wait_cnt == '0) state <= S_COL_ISSUE;
                    else                wait_cnt <= wait_cnt - CNT_W'(1);
                end
                S_COL_ISSUE: begin
                    if (T_BURST == 1) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        state    <= S_BURST_WAIT;
                        wait_cnt <= BURST_LOAD;
                    end
                end
                S_BURST_WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= S_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_cmd_sequencer.sv
// Directed bench for ddr_cmd_sequencer: expected command pulses are queued with
// hand-computed cycle numbers and a negedge monitor pops and compares them.
module tb_ddr_cmd_sequencer;
  import ddr_pkg::*;

  localparam int W = 66;
  localparam logic [2:0] K_ERR = 3'd7;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req_valid = 1'b0;
  logic [1:0]       req_op = 2'd0;
  logic [32:0]      req_addr = '0;
  logic             req_ready;
  logic             cmd_valid;
  logic [2:0]       cmd_type;
  logic [1:0]       cmd_bg;
  logic [1:0]       cmd_bank;
  logic [14:0]      cmd_row;
  logic [10:0]      cmd_col;
  logic             req_done;
  logic             req_err;
  seq_state_e       state_dbg;

  ddr_cmd_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .cmd_valid (cmd_valid),
    .cmd_type  (cmd_type),
    .cmd_bg    (cmd_bg),
    .cmd_bank  (cmd_bank),
    .cmd_row   (cmd_row),
    .cmd_col   (cmd_col),
    .req_done  (req_done),
    .req_err   (req_err),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    repeat (3000) @(posedge clk);
    $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;
  int n_exp_cmd = 0;
  int n_cmd_seen = 0;
  int last_act [16];
  bit act_seen [16];

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s at cyc %0d: got %h expected %h", name, cyc, got, exp);
  endtask

  task automatic expect_out(input int c, input logic [2:0] k, input logic [1:0] bg,
                            input logic [1:0] bk, input logic [14:0] row, input logic [10:0] col);
    logic d;
    d = (k == CMD_RD) || (k == CMD_WR);
    exp_q.push_back({32'(c), k, d, bg, bk, row, col});
    if (k != K_ERR) n_exp_cmd++;
  endtask

  // ---------------- monitor ----------------
  logic [W-1:0] mon_act;
  logic [W-1:0] mon_exp;
  int           mon_idx;

  always @(negedge clk) begin
    if (!rst) begin
      if (cmd_valid) n_cmd_seen++;
      if (cmd_valid || req_err || req_done) begin
        mon_act = {32'(cyc), (req_err ? K_ERR : cmd_type), req_done, cmd_bg, cmd_bank, cmd_row, cmd_col};
        if (exp_q.size() == 0) begin
          check("unexpected_output", mon_act, '0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("cmd_stream", mon_act, mon_exp);
        end
      end
      if (cmd_valid) begin
        mon_idx = int'({cmd_bg, cmd_bank});
        if ((cmd_type == CMD_RD || cmd_type == CMD_WR) && act_seen[mon_idx])
          check("trcd_gap_ok", W'(cyc - last_act[mon_idx] >= 24), W'(1));
        if (cmd_type == CMD_PRE && act_seen[mon_idx])
          check("tras_gap_ok", W'(cyc - last_act[mon_idx] >= 52), W'(1));
        if (cmd_type == CMD_ACT) begin
          last_act[mon_idx] = cyc;
          act_seen[mon_idx] = 1'b1;
        end
      end
    end
  end

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic [1:0] op, input logic [32:0] addr, input int exp_acc);
    int budget;
    int acc;
    budget = 200;
    acc = -1;
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    while (!req_ready && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (req_ready) acc = cyc;
    check("accept_cycle", W'(acc), W'(exp_acc));
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int budget;

    // Reset values while rst is held
    @(negedge clk);
    check("reset_outputs", W'({req_ready, cmd_valid, cmd_type, req_done, req_err}), W'({1'b1, 1'b0, 3'd0, 1'b0, 1'b0}));
    check("reset_state", W'(state_dbg), W'(S_IDLE));
    @(negedge clk);
    rst = 1'b0;
    while (cyc < 10) @(negedge clk);

    // 1: closed bank -> ACT @11, RD @35, ready @39
    expect_out(11, CMD_ACT, 2'd1, 2'd0, 15'd0, 11'd0);
    expect_out(35, CMD_RD,  2'd1, 2'd0, 15'd0, 11'd0);
    send(2'd0, 33'h0_0000_0040, 10);

    // 2: row hit, held valid while busy -> accepted @39, RD col1 @40
    expect_out(40, CMD_RD, 2'd1, 2'd0, 15'd0, 11'd1);
    send(2'd0, 33'h0_0000_0048, 39);

    // 3: row miss -> PRE waits for tRAS (@63), ACT row1 @87, RD @111
    expect_out(63,  CMD_PRE, 2'd1, 2'd0, 15'd0, 11'd0);
    expect_out(87,  CMD_ACT, 2'd1, 2'd0, 15'd1, 11'd0);
    expect_out(111, CMD_RD,  2'd1, 2'd0, 15'd0, 11'd0);
    send(2'd0, 33'h0_0004_0040, 44);

    // 4: illegal op -> err @116, no command, ready held
    expect_out(116, K_ERR, 2'd0, 2'd0, 15'd0, 11'd0);
    send(2'd3, 33'h1_2345_6789, 115);
    check("err_ready_held", W'(req_ready), W'(1));
    check("err_no_cmd", W'(cmd_valid), W'(0));

    // 5: write to bg2 bk3 while bg1 bk0 holds row1, then fetch that row as a hit
    expect_out(117, CMD_ACT, 2'd2, 2'd3, 15'd0, 11'd0);
    expect_out(141, CMD_WR,  2'd2, 2'd3, 15'd0, 11'd0);
    send(2'd1, 33'h0_0000_0380, 116);
    expect_out(146, CMD_RD, 2'd1, 2'd0, 15'd0, 11'd0);
    send(2'd2, 33'h0_0004_0040, 145);

    // 6: reset 5 cycles after ACT aborts the request; retry starts from a closed bank
    expect_out(151, CMD_ACT, 2'd0, 2'd1, 15'd0, 11'd0);
    send(2'd0, 33'h0_0000_0100, 150);
    while (cyc < 156) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_outputs", W'({req_ready, cmd_valid, cmd_type, req_done, req_err}), W'({1'b1, 1'b0, 3'd0, 1'b0, 1'b0}));
    check("midrst_state", W'(state_dbg), W'(S_IDLE));
    rst = 1'b0;
    expect_out(158, CMD_ACT, 2'd0, 2'd1, 15'd0, 11'd0);
    expect_out(182, CMD_RD,  2'd0, 2'd1, 15'd0, 11'd0);
    send(2'd0, 33'h0_0000_0100, 157);

    // Burst spacing boundary: ready low at C+3, high at C+4
    while (cyc < 185) @(negedge clk);
    check("burst_ready_low", W'(req_ready), W'(0));
    @(negedge clk);
    check("burst_ready_high", W'(req_ready), W'(1));

    budget = 50;
    while (exp_q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (10) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), W'(0));
    check("cmd_count", W'(n_cmd_seen), W'(n_exp_cmd));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
